// File: rtl/ps2_pkg.sv
// Shared types and constants for the PS/2 host transmitter.
// Frame layout: 8 data bits LSB first, odd parity, stop, device ACK on the 11th clock edge.
package ps2_pkg;

  localparam int unsigned DataBits   = 8;
  localparam int unsigned FrameEdges = 11;
  localparam int unsigned StopEdge   = FrameEdges - 1;
  localparam int unsigned EdgeW      = $clog2(FrameEdges + 1);
  localparam int unsigned BitIdxW    = $clog2(DataBits);

  localparam logic [DataBits-1:0] CmdSetLeds = 8'hED;
  localparam logic [DataBits-1:0] CmdEnable  = 8'hF4;
  localparam logic [DataBits-1:0] CmdReset   = 8'hFF;

  typedef enum logic [2:0] {
    IDLE      = 3'd0,
    INHIBIT   = 3'd1,
    START     = 3'd2,
    XFER      = 3'd3,
    ACK       = 3'd4,
    WAIT_IDLE = 3'd5
  } state_e;

  typedef struct packed {
    logic [DataBits-1:0] data;
    logic                parity;
  } txFrame_t;

  // Odd parity: the bit that makes the total count of ones odd.
  function automatic logic oddParity(input logic [DataBits-1:0] d);
    return ~(^d);
  endfunction

endpackage

// File: rtl/ps2_line_sync.sv
// Two-flop synchronizers for the PS/2 pads and falling-edge detection on the clock line.
// PS2_TX_GLITCH_FILTER_EN adds a 4-sample stability filter on the synchronized clock.
module ps2_line_sync
  import ps2_pkg::*;
(
  input  logic clk,
  input  logic rst,
  input  logic ps2ClkRaw,
  input  logic ps2DataRaw,
  output logic clkLevel_c,
  output logic dataLevel,
  output logic clkFall_c
);

  logic [1:0] clkSync;
  logic [1:0] dataSync;
  logic       clkPrev;

  // Lines idle high, so synchronizers reset to 1 to avoid a false edge after reset.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      clkSync  <= 2'b11;
      dataSync <= 2'b11;
    end else begin
      clkSync  <= {clkSync[0], ps2ClkRaw};
      dataSync <= {dataSync[0], ps2DataRaw};
    end
  end

  assign dataLevel = dataSync[1];

`ifdef PS2_TX_GLITCH_FILTER_EN
  logic [2:0] clkHist;
  logic       clkFilt;

  // Level follows the input only once it and the three previous samples agree.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      clkHist <= 3'b111;
      clkFilt <= 1'b1;
    end else begin
      clkHist <= {clkHist[1:0], clkSync[1]};
      clkFilt <= clkLevel_c;
    end
  end

  assign clkLevel_c = (clkHist == {3{clkSync[1]}}) ? clkSync[1] : clkFilt;
`else
  assign clkLevel_c = clkSync[1];
`endif

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      clkPrev <= 1'b1;
    end else begin
      clkPrev <= clkLevel_c;
    end
  end

  assign clkFall_c = clkPrev & ~clkLevel_c;

endmodule

// File: rtl/ps2_host_tx.sv
// PS/2 host-to-device transmitter: inhibit, start bit, data/parity/stop on device clock, ACK check.
// Build option PS2_TX_GLITCH_FILTER_EN enables the clock glitch filter in ps2_line_sync.
module ps2_host_tx
  import ps2_pkg::*;
#(
  parameter int unsigned INHIBIT_CYCLES = 12000,
  parameter int unsigned TIMEOUT_CYCLES = 2000000
) (
  input  logic                clk,
  input  logic                rst,
  input  logic [DataBits-1:0] tx_data,
  input  logic                tx_valid,
  output logic                tx_ready,
  input  logic                ps2_clk_i,
  input  logic                ps2_data_i,
  output logic                ps2_clk_oe,
  output logic                ps2_data_oe,
  output logic                busy,
  output logic                done,
  output logic                ack_err,
  output logic                timeout
);

  localparam int unsigned CntMax = (INHIBIT_CYCLES > TIMEOUT_CYCLES) ? INHIBIT_CYCLES
                                                                     : TIMEOUT_CYCLES;
  localparam int unsigned CntW   = $clog2(CntMax + 1);

  state_e            state;
  state_e            nextState;
  txFrame_t          frame;
  txFrame_t          frameNext;
  logic [CntW-1:0]   cnt;
  logic [CntW-1:0]   cntNext;
  logic [EdgeW-1:0]  edgeIdx;
  logic [EdgeW-1:0]  edgeNext;
  logic              ackFlag;
  logic              ackFlagNext;
  logic              clkOeNext;
  logic              dataOeNext;
  logic              doneNext;
  logic              ackErrNext;
  logic              timeoutNext;

  logic              clkLevel_c;
  logic              dataLevel;
  logic              clkFall_c;
  logic              accept_c;
  logic              inhibitDone_c;
  logic              timeoutHit_c;

  ps2_line_sync u_sync (
    .clk        (clk),
    .rst        (rst),
    .ps2ClkRaw  (ps2_clk_i),
    .ps2DataRaw (ps2_data_i),
    .clkLevel_c (clkLevel_c),
    .dataLevel  (dataLevel),
    .clkFall_c  (clkFall_c)
  );

  assign accept_c      = tx_valid & tx_ready;
  assign inhibitDone_c = (cnt == CntW'(INHIBIT_CYCLES - 1));
  assign timeoutHit_c  = (cnt == CntW'(TIMEOUT_CYCLES - 1));

  // State and registered outputs; reset releases both pads asynchronously.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state       <= IDLE;
      frame       <= '0;
      cnt         <= '0;
      edgeIdx     <= '0;
      ackFlag     <= 1'b0;
      ps2_clk_oe  <= 1'b0;
      ps2_data_oe <= 1'b0;
      done        <= 1'b0;
      ack_err     <= 1'b0;
      timeout     <= 1'b0;
      tx_ready    <= 1'b1;
      busy        <= 1'b0;
    end else begin
      state       <= nextState;
      frame       <= frameNext;
      cnt         <= cntNext;
      edgeIdx     <= edgeNext;
      ackFlag     <= ackFlagNext;
      ps2_clk_oe  <= clkOeNext;
      ps2_data_oe <= dataOeNext;
      done        <= doneNext;
      ack_err     <= ackErrNext;
      timeout     <= timeoutNext;
      tx_ready    <= (nextState == IDLE);
      busy        <= (nextState != IDLE);
    end
  end

  // Next-state logic; a clock edge wins over a simultaneous timeout.
  always_comb begin
    nextState = state;
    case (state)
      IDLE:      if (accept_c) nextState = INHIBIT;
      INHIBIT:   if (inhibitDone_c) nextState = START;
      START:     nextState = XFER;
      XFER: begin
        if (clkFall_c) begin
          if (edgeIdx == EdgeW'(StopEdge - 1)) nextState = ACK;
        end else if (timeoutHit_c) begin
          nextState = IDLE;
        end
      end
      ACK: begin
        if (clkFall_c)         nextState = WAIT_IDLE;
        else if (timeoutHit_c) nextState = IDLE;
      end
      WAIT_IDLE: if (clkLevel_c && dataLevel) nextState = IDLE;
      default:   nextState = IDLE;
    endcase
  end

  // Datapath and output next values.
  always_comb begin
    frameNext   = frame;
    cntNext     = cnt;
    edgeNext    = edgeIdx;
    ackFlagNext = ackFlag;
    clkOeNext   = ps2_clk_oe;
    dataOeNext  = ps2_data_oe;
    doneNext    = 1'b0;
    ackErrNext  = 1'b0;
    timeoutNext = 1'b0;
    case (state)
      IDLE: begin
        if (accept_c) begin
          frameNext.data   = tx_data;
          frameNext.parity = oddParity(tx_data);
          clkOeNext        = 1'b1;
          cntNext          = '0;
          ackFlagNext      = 1'b0;
        end
      end
      INHIBIT: begin
        if (inhibitDone_c) dataOeNext = 1'b1;
        else               cntNext    = cnt + CntW'(1);
      end
      START: begin
        clkOeNext = 1'b0;
        cntNext   = '0;
        edgeNext  = '0;
      end
      XFER: begin
        cntNext = cnt + CntW'(1);
        if (clkFall_c) begin
          edgeNext = edgeIdx + EdgeW'(1);
          // Open drain: oe=1 drives a 0, so each bit goes out inverted.
          if (edgeIdx < EdgeW'(DataBits))
            dataOeNext = ~frame.data[edgeIdx[BitIdxW-1:0]];
          else if (edgeIdx == EdgeW'(DataBits))
            dataOeNext = ~frame.parity;
          else
            dataOeNext = 1'b0;
        end else if (timeoutHit_c) begin
          clkOeNext   = 1'b0;
          dataOeNext  = 1'b0;
          doneNext    = 1'b1;
          timeoutNext = 1'b1;
        end
      end
      ACK: begin
        cntNext = cnt + CntW'(1);
        if (clkFall_c) begin
          ackFlagNext = dataLevel;
        end else if (timeoutHit_c) begin
          clkOeNext   = 1'b0;
          dataOeNext  = 1'b0;
          doneNext    = 1'b1;
          timeoutNext = 1'b1;
        end
      end
      WAIT_IDLE: begin
        if (clkLevel_c && dataLevel) begin
          doneNext   = 1'b1;
          ackErrNext = ackFlag;
        end
      end
      default: begin
        clkOeNext  = 1'b0;
        dataOeNext = 1'b0;
      end
    endcase
  end

endmodule

// File: tb/tb_ps2_host_tx.sv
// Scoreboard bench for ps2_host_tx: stimulus queues expected completions, a monitor checks each done.
module tb_ps2_host_tx;
  import ps2_pkg::*;

  localparam int unsigned Inh  = 20;
  localparam int unsigned Tmo  = 400;
  localparam int unsigned Half = 10;

  typedef struct packed {
    logic [9:0] seq;
    logic       chkSeq;
    logic       ackErr;
    logic       tmo;
  } exp_t;

  logic       clk = 1'b0;
  logic       rst;
  logic [7:0] tx_data;
  logic       tx_valid;
  logic       tx_ready;
  logic       ps2_clk_i;
  logic       ps2_data_i;
  logic       ps2_clk_oe;
  logic       ps2_data_oe;
  logic       busy;
  logic       done;
  logic       ack_err;
  logic       timeout;
  logic       devClk;
  logic       devData;

  exp_t       expQ[$];
  int         errors = 0;
  int         checks = 0;
  int         cyc = 0;
  int         relCyc = 0;
  int         hiRun = 0;
  int         doneCnt = 0;
  int         acceptCnt = 0;
  logic       prevClkOe = 1'b0;
  logic [9:0] obsSeq = '0;

  always #5 clk = ~clk;

  ps2_host_tx #(.INHIBIT_CYCLES(Inh), .TIMEOUT_CYCLES(Tmo)) dut (
    .clk         (clk),
    .rst         (rst),
    .tx_data     (tx_data),
    .tx_valid    (tx_valid),
    .tx_ready    (tx_ready),
    .ps2_clk_i   (ps2_clk_i),
    .ps2_data_i  (ps2_data_i),
    .ps2_clk_oe  (ps2_clk_oe),
    .ps2_data_oe (ps2_data_oe),
    .busy        (busy),
    .done        (done),
    .ack_err     (ack_err),
    .timeout     (timeout)
  );

  // Open-drain pads: either side can pull low.
  assign ps2_clk_i  = devClk & ~ps2_clk_oe;
  assign ps2_data_i = devData & ~ps2_data_oe;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, req, $time);
    end
  endtask

  task automatic tick(input int n = 1);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  // Monitor: pops an expectation on every done and checks the completion state.
  always @(negedge clk) begin
    exp_t e;
    if (!rst) begin
      hiRun     = 0;
      prevClkOe = 1'b0;
    end else begin
      if (ps2_clk_oe) begin
        hiRun++;
      end else if (prevClkOe) begin
        check("clk_oe_hold", 32'(hiRun), 32'(Inh + 1));
        relCyc = cyc;
        hiRun  = 0;
      end
      prevClkOe = ps2_clk_oe;
      if ((ack_err || timeout) && !done) begin
        checks++;
        errors++;
        $display("FAIL status_without_done: ack_err=%0b timeout=%0b", ack_err, timeout);
      end
      if (done) begin
        doneCnt++;
        if (expQ.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_done: got done=1, expected no completion");
        end else begin
          e = expQ.pop_front();
          check("ack_err", 32'(ack_err), 32'(e.ackErr));
          check("timeout", 32'(timeout), 32'(e.tmo));
          check("done_ready", 32'(tx_ready), 32'd1);
          check("done_oe", 32'({ps2_clk_oe, ps2_data_oe}), 32'd0);
          if (e.chkSeq) check("data_oe_seq", 32'(obsSeq), 32'(e.seq));
          if (e.tmo) check("timeout_latency", 32'(cyc - relCyc), 32'(Tmo));
        end
      end
    end
  end

  task automatic send(input logic [7:0] b, input exp_t e, input bit push);
    int t = 0;
    while (!tx_ready && t < 2000) begin
      tick();
      t++;
    end
    if (!tx_ready) begin
      checks++;
      errors++;
      $display("FAIL send_ready: got tx_ready=0, expected 1 within 2000 cycles");
    end
    tx_data  = b;
    tx_valid = 1'b1;
    if (push) begin
      expQ.push_back(e);
      acceptCnt++;
    end
    tick();
    tx_valid = 1'b0;
  endtask

  task automatic waitIdle();
    int t = 0;
    while (busy && t < 1000) begin
      tick();
      t++;
    end
    if (busy) begin
      checks++;
      errors++;
      $display("FAIL wait_idle: got busy=1, expected 0 within 1000 cycles");
    end
    tick(3);
  endtask

  // Device model: waits for clock release, clocks nEdges, samples host data on each rising edge.
  task automatic device(input int nEdges, input bit ack, input int abortEdge);
    int t = 0;
    while (!ps2_clk_oe && t < 100) begin
      tick();
      t++;
    end
    while (ps2_clk_oe && t < 100 + Inh + 20) begin
      tick();
      t++;
    end
    if (ps2_clk_oe || t >= 100 + Inh + 20) begin
      checks++;
      errors++;
      $display("FAIL clk_release: got no release of clock, expected release after inhibit");
    end
    obsSeq = '0;
    tick(3);
    for (int k = 1; k <= nEdges; k++) begin
      devClk = 1'b0;
      if (k == abortEdge) begin
        tick(8);
        check("abort_pre_oe", 32'(ps2_data_oe), 32'd1);
        #2 rst = 1'b0;
        #1;
        check("abort_oe", 32'({ps2_clk_oe, ps2_data_oe}), 32'd0);
        devClk = 1'b1;
        return;
      end
      tick(Half);
      if (k <= 10) obsSeq[k-1] = ps2_data_oe;
      devClk = 1'b1;
      if (k == 10 && ack) devData = 1'b0;
      tick(Half);
      if (k == 11) devData = 1'b1;
    end
  endtask

  initial begin
    tx_valid = 1'b0;
    tx_data  = '0;
    devClk   = 1'b1;
    devData  = 1'b1;
    rst      = 1'b0;
    tick(3);
    check("rst_ready", 32'(tx_ready), 32'd1);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_oe", 32'({ps2_clk_oe, ps2_data_oe}), 32'd0);
    check("rst_status", 32'({done, ack_err, timeout}), 32'd0);
    rst = 1'b1;
    tick(3);

    // 0xED: oe per edge 0,1,0,0,1,0,0,0, parity oe 0, stop oe 0; device ACKs
    send(CmdSetLeds, '{10'h012, 1'b1, 1'b0, 1'b0}, 1'b1);
    device(11, 1'b1, 0);
    waitIdle();

    // 0x01: parity bit 0, so oe=1 on edge 9
    send(8'h01, '{10'h1FE, 1'b1, 1'b0, 1'b0}, 1'b1);
    device(11, 1'b1, 0);
    waitIdle();

    // 0xF4 with no ACK from the device
    send(CmdEnable, '{10'h10B, 1'b1, 1'b1, 1'b0}, 1'b1);
    device(11, 1'b0, 0);
    waitIdle();

    // Silent device: timeout exactly Tmo cycles after clock release
    send(8'hA5, '{10'h000, 1'b0, 1'b0, 1'b1}, 1'b1);
    waitIdle();

    // Reset during edge 5: no completion expected
    send(8'h00, '{10'h000, 1'b0, 1'b0, 1'b0}, 1'b0);
    device(11, 1'b1, 5);
    tick(3);
    rst = 1'b1;
    tick(3);
    check("post_abort_ready", 32'(tx_ready), 32'd1);
    check("post_abort_busy", 32'(busy), 32'd0);

    // 0xFF after the abort, with a request pulsed while busy
    send(CmdReset, '{10'h000, 1'b1, 1'b0, 1'b0}, 1'b1);
    tick(5);
    tx_data  = 8'h55;
    tx_valid = 1'b1;
    tick();
    tx_valid = 1'b0;
    check("busy_during_xfer", 32'({busy, tx_ready}), 32'b10);
    device(11, 1'b1, 0);
    waitIdle();
    tick(20);

    check("queue_drained", 32'(expQ.size()), 32'd0);
    check("done_count", 32'(doneCnt), 32'(acceptCnt));
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/ps2_host_tx.md
PS2_HOST_TX -- requirements
Module: ps2_host_tx

Interface
REQ-001 SHALL have parameter INHIBIT_CYCLES, default 12000: clk cycles PS2 clock is held low before the start bit (120 us at 100 MHz).
REQ-002 SHALL have parameter TIMEOUT_CYCLES, default 2000000: maximum cycles from clock release to ACK (20 ms at 100 MHz).
REQ-003 SHALL have port clk  input  1  system clock; all state on its rising edge.
REQ-004 SHALL have port rst  input  1  reset, asynchronous, active-low.
REQ-005 SHALL have port tx_data  input  8  command byte to send to the keyboard.
REQ-006 SHALL have port tx_valid  input  1  request; byte accepted when tx_valid and tx_ready are both high.
REQ-007 SHALL have port tx_ready  output  1  high only in IDLE.
REQ-008 SHALL have port ps2_clk_i / ps2_data_i  input  1 each  raw PS2_CLK / PS2_DATA pad levels.
REQ-009 SHALL have port ps2_clk_oe / ps2_data_oe  output  1 each  1 = drive pad low, 0 = release (open drain).
REQ-010 SHALL have port busy  output  1  high from acceptance until return to IDLE.
REQ-011 SHALL have port done  output  1  one-cycle pulse at end of every accepted transfer.
REQ-012 SHALL have port ack_err / timeout  output  1 each  one-cycle status pulses, asserted only together with done.

Function
REQ-013 SHALL implement states IDLE, INHIBIT, START, XFER, ACK, WAIT_IDLE.
REQ-014 On acceptance, SHALL latch tx_data, compute the odd parity bit (XNOR of the 8 bits), set ps2_clk_oe=1 and enter INHIBIT.
REQ-015 INHIBIT SHALL last exactly INHIBIT_CYCLES cycles, then set ps2_data_oe=1 (start bit) and enter START with ps2_clk_oe still 1.
REQ-016 START SHALL last one cycle, then set ps2_clk_oe=0, clear the timeout counter, set the edge index to 0 and enter XFER.
REQ-017 In XFER, on device falling edges 1-8, ps2_data_oe SHALL become the inverse of data bit 0-7 (LSB first); on edge 9, the inverse of parity; on edge 10, 0 (stop bit); then enter ACK.
REQ-018 In ACK, on the next falling edge (11th), SHALL sample the synchronized data line; high sets the ack_err flag; then enter WAIT_IDLE.
REQ-019 WAIT_IDLE SHALL wait until synchronized clock and data are both high, then pulse done (with ack_err if flagged) and enter IDLE.
REQ-020 If the counter reaches TIMEOUT_CYCLES in XFER or ACK, both oe SHALL be 0 the next cycle, done and timeout SHALL pulse, and the block SHALL enter IDLE.
REQ-021 A falling edge and counter expiry in the same cycle: the edge SHALL take priority.
REQ-022 tx_valid while busy SHALL be ignored; no queuing.
REQ-023 Edge detection SHALL use a 2-flop synchronizer on ps2_clk_i and ps2_data_i; a falling edge is synchronized high then low in consecutive cycles.

Reset
REQ-024 While rst=0: state IDLE; ps2_clk_oe, ps2_data_oe, busy, done, ack_err, timeout = 0; tx_ready = 1; counters and synchronizers = 0 or idle-high as appropriate.
REQ-025 Reset mid-transfer SHALL release both lines immediately and asynchronously; no done pulse.

Configuration
REQ-026 Macro PS2_TX_GLITCH_FILTER_EN defined: the synchronized clock SHALL change its filtered level only after 4 consecutive equal samples, adding 3 cycles of edge latency.
REQ-027 Macro PS2_TX_GLITCH_FILTER_EN undefined: the filter SHALL be absent and edges SHALL come directly from the 2-flop synchronizer.

Structure
REQ-028 Package ps2_pkg SHALL hold the state enum, frame constants (8 data bits, 11 edges) and command codes (0xED set LEDs, 0xF4 enable, 0xFF reset).
REQ-029 Sub-module ps2_line_sync SHALL contain the synchronizers, the optional filter and falling-edge detection; the FSM stays in ps2_host_tx.

Verification
REQ-030 Send 0xED with a device model that ACKs -> data_oe sequence 0,1,0,0,1,0,0,0 then parity bit 1 (oe 0), stop (oe 0); done=1, ack_err=0.
REQ-031 Send 0x01 -> parity bit 0 (oe 1 on edge 9).
REQ-032 Device model with no ACK on edge 11 -> done and ack_err pulse together; timeout=0.
REQ-033 Device never clocks -> exactly TIMEOUT_CYCLES after clock release: done and timeout pulse, both oe=0, tx_ready=1.
REQ-034 Assert rst=0 during edge 5 -> both oe=0 in the same cycle; no done; next 0xFF transfer completes normally.
REQ-035 Pulse tx_valid while busy -> ignored; exactly one done per accepted byte; ps2_clk_oe held exactly INHIBIT_CYCLES+1 cycles.
